// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - bus-mapped UART transmitter with transmit FIFO and programmable divisor
// Define UART_TX_PARITY_EN to append an even-parity bit after the 8 data bits.
module uart_tx #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_RST    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        tx
);

   localparam int         PW    = $clog2(FIFO_DEPTH);
   localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [4:0]      count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            en_q, en_d, im_q, im_d;
   logic [15:0]     div_q, div_d;
   logic [15:0]     baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic            tx_q, tx_d;
   logic            irq_q;

   logic            wr_data, wr_ctrl, wr_status, wr_div;
   logic            full, empty, busy, push, pop, bit_done;
   logic [15:0]     reload;
   logic [7:0]      head;
   logic            unused_bits;

   assign unused_bits = ^{Addr[31:4], Din[31:16]};

   assign wr_data   = WE && (Addr[3:2] == 2'd0);
   assign wr_ctrl   = WE && (Addr[3:2] == 2'd1);
   assign wr_status = WE && (Addr[3:2] == 2'd2);
   assign wr_div    = WE && (Addr[3:2] == 2'd3);

   assign full     = (count_q == DEPTH);
   assign empty    = (count_q == 5'd0);
   assign busy     = (state_q != S_IDLE);
   assign head     = mem_q[rptr_q];
   assign bit_done = (baud_q == 16'd0);
   // A divisor of 0 behaves like 1; the reload samples DIV so mid-frame writes apply at the next bit.
   assign reload   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign push = wr_data && (!full || pop);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en_q && !empty) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = ^head;
               baud_d  = reload;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               baud_d  = reload;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               baud_d  = reload;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) begin
               baud_d  = reload;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (bit_done) begin
               if (en_q && !empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  par_d   = ^head;
                  baud_d  = reload;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 5'd1;
      end else if (pop && !push) begin
         count_d = count_q - 5'd1;
      end
      ovf_d = ovf_q;
      if (wr_status) begin
         ovf_d = 1'b0;
      end else if (wr_data && !push) begin
         ovf_d = 1'b1;
      end
      en_d  = wr_ctrl ? Din[0] : en_q;
      im_d  = wr_ctrl ? Din[1] : im_q;
      div_d = wr_div ? Din[15:0] : div_q;
   end

   always_comb begin
      Dout = 32'd0;
      case (Addr[3:2])
         2'd1:    Dout = {30'd0, im_q, en_q};
         2'd2:    Dout = {23'd0, count_q, ovf_q, empty, full, busy};
         2'd3:    Dout = {16'd0, div_q};
         default: Dout = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= Din[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= 5'd0;
         ovf_q   <= 1'b0;
         en_q    <= 1'b0;
         im_q    <= 1'b0;
         div_q   <= 16'(DIV_RST);
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         en_q    <= en_d;
         im_q    <= im_d;
         div_q   <= div_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         irq_q   <= im_q && empty && (state_q == S_IDLE);
      end
   end

   assign tx  = tx_q;
   assign IRQ = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed scoreboard bench for uart_tx
// Frames are captured sample-by-sample and compared against bytes queued when written.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        tx;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic        cap_en   = 1'b0;
   logic        cap[$];
   logic [7:0]  exp_q[$];

   uart_tx #(.FIFO_DEPTH(4), .DIV_RST(16)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #2;
      if (cap_en) cap.push_back(tx);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      @(negedge clk);
      WE   = 1'b0;
      Din  = 32'd0;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      Addr = {28'd0, a};
      #1;
      chk(tag, Dout, exp);
   endtask

   function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   task automatic check_frames(input int div, input bit contig, input int lat);
      int             idx   = 0;
      int             zeros = 0;
      int             bl;
      bit             first = 1'b1;
      logic [NB-1:0]  f;
      logic [7:0]     b;
      logic           s;
      bl = (div < 1) ? 1 : div;
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         f = frame_bits(b);
         if (first || !contig)
            while (idx < cap.size() && cap[idx] === 1'b1) idx++;
         if (first && lat >= 0) chk("start_latency", idx, lat);
         first = 1'b0;
         for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < bl; c++) begin
               s = (idx < cap.size()) ? cap[idx] : 1'bx;
               chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, i, c), {31'd0, s}, {31'd0, f[i]});
               idx++;
            end
         end
      end
      while (idx < cap.size()) begin
         if (cap[idx] !== 1'b1) zeros++;
         idx++;
      end
      chk("idle_tail_low_samples", zeros, 0);
      cap.delete();
   endtask

   initial begin
      reset = 1'b0;
      WE    = 1'b0;
      Addr  = '0;
      Din   = 32'd0;
      repeat (3) @(negedge clk);
      rdchk("status_in_reset", 2'd2, 32'h4);
      reset = 1'b1;
      @(negedge clk);
      chk("tx_after_reset", {31'd0, tx}, 32'd1);
      chk("irq_after_reset", {31'd0, IRQ}, 32'd0);
      rdchk("status_after_reset", 2'd2, 32'h4);
      rdchk("ctrl_after_reset", 2'd1, 32'h0);
      rdchk("div_after_reset", 2'd3, 32'd16);
      rdchk("data_reads_zero", 2'd0, 32'h0);

      // 0x55 at DIV=4: exact frame shape, latency and busy window
      wr(2'd3, 32'd4);
      wr(2'd1, 32'd1);
      cap.delete();
      cap_en = 1'b1;
      exp_q.push_back(8'h55);
      wr(2'd0, 32'h55);
      repeat (NB * 4) @(negedge clk);
      rdchk("busy_in_last_stop_cycle", 2'd2, 32'h5);
      @(negedge clk);
      rdchk("idle_after_frame", 2'd2, 32'h4);
      repeat (3) @(negedge clk);
      cap_en = 1'b0;
      check_frames(4, 1'b0, 2);

      // interrupt: masked in, low while busy, high one cycle after idle with empty FIFO
      wr(2'd3, 32'd2);
      wr(2'd1, 32'd3);
      chk("irq_lag_after_ctrl", {31'd0, IRQ}, 32'd0);
      @(negedge clk);
      chk("irq_idle_empty", {31'd0, IRQ}, 32'd1);
      cap.delete();
      cap_en = 1'b1;
      exp_q.push_back(8'hA3);
      wr(2'd0, 32'hA3);
      chk("irq_at_push_edge", {31'd0, IRQ}, 32'd1);
      for (int i = 0; i < NB * 2 + 1; i++) begin
         @(negedge clk);
         chk($sformatf("irq_low_cyc%0d", i), {31'd0, IRQ}, 32'd0);
      end
      @(negedge clk);
      chk("irq_after_idle", {31'd0, IRQ}, 32'd1);
      repeat (2) @(negedge clk);
      cap_en = 1'b0;
      check_frames(2, 1'b0, 2);

      // DIV=0 gives one cycle per bit
      wr(2'd1, 32'd1);
      wr(2'd3, 32'd0);
      cap.delete();
      cap_en = 1'b1;
      exp_q.push_back(8'h07);
      wr(2'd0, 32'h07);
      repeat (NB + 4) @(negedge clk);
      cap_en = 1'b0;
      rdchk("status_after_div0", 2'd2, 32'h4);
      check_frames(0, 1'b0, 2);

      // overflow with transmitter disabled
      wr(2'd1, 32'd0);
      wr(2'd3, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(8'(i * 16));
         wr(2'd0, 32'(i * 16));
      end
      wr(2'd0, 32'h99);
      rdchk("status_overflow", 2'd2, 32'h4A);
      wr(2'd2, 32'hFFFF_FFFF);
      rdchk("status_ovf_cleared", 2'd2, 32'h42);

      // push into the full FIFO on the pop edges, frames back to back
      cap.delete();
      cap_en = 1'b1;
      wr(2'd1, 32'd1);
      exp_q.push_back(8'h01);
      wr(2'd0, 32'h01);
      repeat (NB - 1) @(negedge clk);
      exp_q.push_back(8'h02);
      wr(2'd0, 32'h02);
      repeat (6 * NB + 5) @(negedge clk);
      cap_en = 1'b0;
      rdchk("status_after_burst", 2'd2, 32'h4);
      check_frames(1, 1'b1, 2);

      // reset in the middle of a 0xFF frame
      wr(2'd3, 32'd4);
      wr(2'd0, 32'hFF);
      repeat (12) @(negedge clk);
      rdchk("busy_before_abort", 2'd2, 32'h5);
      reset = 1'b0;
      #1;
      chk("tx_on_reset", {31'd0, tx}, 32'd1);
      chk("irq_on_reset", {31'd0, IRQ}, 32'd0);
      rdchk("status_on_reset", 2'd2, 32'h4);
      rdchk("div_on_reset", 2'd3, 32'd16);
      rdchk("ctrl_on_reset", 2'd1, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cap.delete();
      cap_en = 1'b1;
      wr(2'd1, 32'd1);
      repeat (40) @(negedge clk);
      cap_en = 1'b0;
      rdchk("status_after_abort", 2'd2, 32'h4);
      check_frames(16, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of transmit FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_RST, default 16, reset value of the baud divisor.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Addr, input, [31:2], word address from the bridge; only Addr[3:2] is decoded.
REQ-006 SHALL have port WE, input, 1, write strobe from the bridge.
REQ-007 SHALL have port Din, input, 32, write data.
REQ-008 SHALL have port Dout, output, 32, combinational read data for Addr[3:2].
REQ-009 SHALL have port IRQ, output, 1, level interrupt to the CPU HWInt vector.
REQ-010 SHALL have port tx, output, 1, serial line, idle high.

Function
REQ-011 SHALL decode the register map by Addr[3:2]: 0 DATA (write-only), 1 CTRL, 2 STATUS, 3 DIV.
REQ-012 SHALL implement CTRL as 2 bits: [0] EN (transmit enable), [1] IM (interrupt mask); upper bits read 0.
REQ-013 SHALL read STATUS as: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] OVF sticky, [8:4] FIFO count; others 0.
REQ-014 SHALL hold a 16-bit divisor DIV; each serial bit lasts max(DIV,1) clk cycles.
REQ-015 SHALL push Din[7:0] into the FIFO on WE to DATA when not full; when full, data is dropped and OVF set.
REQ-016 SHALL clear OVF on any WE to STATUS; write data ignored.
REQ-017 SHALL read DATA as 0.
REQ-018 SHALL run FSM IDLE -> START -> DATA -> STOP -> IDLE (or START if FIFO non-empty and EN).
REQ-019 SHALL leave IDLE only when EN=1 and FIFO non-empty, popping the head into the shift register on that edge.
REQ-020 SHALL drive tx=0 in START, data bits LSB first in DATA (8 bits), tx=1 in STOP and IDLE.
REQ-021 SHALL keep a bit counter reloaded per bit; a DIV write mid-frame takes effect at the next bit boundary.
REQ-022 SHALL, when EN cleared mid-frame, finish the current frame, then stay IDLE.
REQ-023 SHALL, on a simultaneous push and pop, keep count unchanged and accept the push even if count was FIFO_DEPTH.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-025 SHALL make latency: DATA write at edge k with FIFO empty, IDLE, EN=1 -> tx=0 after edge k+1.
REQ-026 SHALL assert IRQ = IM & empty & (state==IDLE), registered, updating one cycle after the condition.

Reset
REQ-027 SHALL on reset=0, asynchronously: FSM IDLE, tx=1, IRQ=0, FIFO empty, pointers 0, OVF=0, CTRL=0, DIV=DIV_RST.
REQ-028 SHALL abort any frame in progress on reset, with tx returning to 1 immediately; no partial frame resumes.
REQ-029 SHALL drive Dout per REQ-013 reset values after reset (STATUS reads 0x4).

Configuration
REQ-030 SHALL, with macro UART_TX_PARITY_EN defined, insert state PARITY between DATA and STOP sending even parity of the 8 data bits for one bit time.
REQ-031 SHALL, without UART_TX_PARITY_EN, produce 10-bit frames (start, 8 data, stop) and no PARITY state.

Verification
REQ-032 SHALL cover: DIV=4, CTRL=1, write DATA=0x55 -> tx 0,1,0,1,0,1,0,1,0,1 each 4 cycles, busy=0 after 40 cycles.
REQ-033 SHALL cover: EN=0, write 5 bytes with FIFO_DEPTH=4 -> STATUS=0x4A (count 4, full, OVF); write STATUS -> 0x42.
REQ-034 SHALL cover: CTRL=3, DIV=2, write 0xA3 -> IRQ 0 while busy, IRQ=1 one cycle after return to IDLE with FIFO empty.
REQ-035 SHALL cover: reset=0 mid-DATA of 0xFF frame -> tx=1 at once, STATUS=0x4, DIV=16, no further tx activity.
REQ-036 SHALL cover: DIV=0 -> 1 cycle per bit, 10-cycle frame (11 with UART_TX_PARITY_EN, 0x07 parity bit=1).
REQ-037 SHALL cover: back-to-back 0x01,0x02 written at full FIFO during pop -> both sent, STOP followed directly by START.
